// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: reads a little-endian word count, writes
// words to IMEM and releases the CPU. Optional trailing checksum via IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state, state_nx;
    logic [15:0]     len;
    logic [ADDR_W:0] word_cnt;   // one extra bit so a full-depth count fits
    logic [1:0]      byte_idx;
    logic [23:0]     word_buf;
    logic [7:0]      csum;

    logic        accept;
    logic        start_load;
    logic [15:0] len_full;
    logic        len_too_big;
    logic        last_word;

    assign accept      = byte_valid & byte_ready;
    assign start_load  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
    assign len_full    = {byte_data, len[7:0]};
    assign len_too_big = 32'(len_full) > (32'd1 << ADDR_W);
    assign last_word   = (32'(word_cnt) + 32'd1) == 32'(len);

    // NOTE: async reset in the sensitivity list makes the FSM leave mid-load states
    // the instant rst_n falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all registered state, so every
            // flop samples values from before this edge.
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        cpu_rst_n  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LEN_LO;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
                if (start) state_nx = S_LEN_LO;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_nx = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    if (len_too_big)          state_nx = S_ERR;
                    else if (len_full == '0)  state_nx = S_CHK;
                    else                      state_nx = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept && (byte_idx == 2'd3) && last_word) state_nx = S_CHK;
            end
            S_CHK: begin
                busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                byte_ready = 1'b1;
                if (accept) state_nx = (byte_data == csum) ? S_DONE : S_ERR;
`else
                state_nx = S_DONE;
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len        <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_load) begin
                word_cnt <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: len[7:0]  <= byte_data;
                    S_LEN_HI: len[15:8] <= byte_data;
                    S_DATA: begin
                        csum <= csum ^ byte_data;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= {byte_data, word_buf};
                            word_cnt   <= word_cnt + 1'b1;
                            byte_idx   <= '0;
                        end else begin
                            // Shift down so the first byte ends up in bits 7:0.
                            word_buf <= {byte_data, word_buf[23:8]};
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: default-depth instance plus an ADDR_W=2 instance
// for the length-limit cases.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, cpu_rst_n, busy, done, err;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;

    logic        start2 = 1'b0;
    logic        byte_valid2 = 1'b0;
    logic [7:0]  byte_data2 = 8'h00;
    logic        byte_ready2, imem_we2, cpu_rst_n2, busy2, done2, err2;
    logic [1:0]  imem_waddr2;
    logic [31:0] imem_wdata2;

    int total = 0;
    int bad = 0;
    logic [31:0] cyc = '0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;
    wr_t exp_q[$];

    int         w2_cnt = 0;
    logic [1:0] w2_last = '0;

    imem_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
        .busy(busy), .done(done), .err(err)
    );

    imem_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .byte_valid(byte_valid2),
        .byte_data(byte_data2), .byte_ready(byte_ready2), .imem_we(imem_we2),
        .imem_waddr(imem_waddr2), .imem_wdata(imem_wdata2), .cpu_rst_n(cpu_rst_n2),
        .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write strobe must match the oldest expected write, including
    // the cycle it should appear in.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h", imem_waddr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (imem_waddr !== e.addr || imem_wdata !== e.data || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             imem_waddr, imem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        if (rst_n && imem_we2) begin
            w2_cnt++;
            w2_last = imem_waddr2;
        end
    end

    task automatic chk1(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_data  = 8'hA5;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [9:0] addr, input logic [31:0] w, input bit gap);
        wr_t e;
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1;
            byte_data  = w[8*i +: 8];
            @(posedge clk); #1;
            byte_valid = 1'b0;
            byte_data  = 8'hA5;
            if (i == 3) begin
                e.addr = addr; e.data = w; e.cyc = cyc;
                exp_q.push_back(e);
            end
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(done || err) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk); @(negedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending_writes got=%0d want=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        chk1("rst_byte_ready", byte_ready, 1'b0);
        chk1("rst_imem_we", imem_we, 1'b0);
        chk1("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        total++;
        if (imem_waddr !== '0 || imem_wdata !== '0) begin
            bad++;
            $display("FAIL rst_wbus got=%0d/%h want=0/0", imem_waddr, imem_wdata);
        end
    endtask

    task automatic test_basic;
        pulse_start();
        chk1("basic_busy", busy, 1'b1);
        chk1("basic_ready", byte_ready, 1'b1);
        chk1("basic_cpu_held", cpu_rst_n, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(10'd0, 32'h0000_0013, 1'b0);
        send_word(10'd1, 32'h0000_006F, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h13 ^ 8'h6F, 1'b0);
`endif
        wait_end("basic");
        chk1("basic_done", done, 1'b1);
        chk1("basic_cpu_run", cpu_rst_n, 1'b1);
        chk1("basic_busy_end", busy, 1'b0);
        chk1("basic_ready_end", byte_ready, 1'b0);
    endtask

    // Gapped stream, with start held high throughout to show it is ignored while busy.
    task automatic test_gaps;
        pulse_start();
        chk1("gaps_done_clr", done, 1'b0);
        start = 1'b1;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(10'd0, 32'h0000_0013, 1'b1);
        send_word(10'd1, 32'h0000_006F, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h13 ^ 8'h6F, 1'b1);
`endif
        start = 1'b0;
        wait_end("gaps");
        chk1("gaps_done", done, 1'b1);
        chk1("gaps_cpu_run", cpu_rst_n, 1'b1);
    endtask

    task automatic test_zero_len;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        wait_end("zero");
        chk1("zero_done", done, 1'b1);
        chk1("zero_err", err, 1'b0);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(10'd0, 32'h0000_0013, 1'b0);
        send_byte(8'h12, 1'b0);
        wait_end("csum_bad");
        chk1("csum_bad_err", err, 1'b1);
        chk1("csum_bad_cpu", cpu_rst_n, 1'b0);
        pulse_start();
        chk1("csum_err_clr", err, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(10'd0, 32'h0000_0013, 1'b0);
        send_byte(8'h13, 1'b0);
        wait_end("csum_good");
        chk1("csum_good_done", done, 1'b1);
    endtask
`endif

    task automatic send_byte2(input logic [7:0] b);
        byte_valid2 = 1'b1;
        byte_data2  = b;
        @(posedge clk); #1;
        byte_valid2 = 1'b0;
    endtask

    task automatic test_len_limit;
        start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
        send_byte2(8'h05);
        send_byte2(8'h00);
        for (int i = 0; i < 8; i++) send_byte2(8'h11);
        @(negedge clk);
        chk1("over_err", err2, 1'b1);
        chk1("over_cpu", cpu_rst_n2, 1'b0);
        chk1("over_busy", busy2, 1'b0);
        total++;
        if (w2_cnt != 0) begin
            bad++;
            $display("FAIL over_writes got=%0d want=0", w2_cnt);
        end
        #1;
        // Exactly full depth is legal and must end on the last address.
        start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
        send_byte2(8'h04);
        send_byte2(8'h00);
        for (int i = 0; i < 16; i++) send_byte2(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte2(8'h00);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("full_done", done2, 1'b1);
        total++;
        if (w2_cnt != 4 || w2_last !== 2'd3) begin
            bad++;
            $display("FAIL full_writes got=%0d/%0d want=4/3", w2_cnt, w2_last);
        end
        #1;
    endtask

    task automatic test_reset_mid;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(10'd0, 32'hDEAD_BEEF, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_busy", busy, 1'b0);
        chk1("mid_ready", byte_ready, 1'b0);
        chk1("mid_we", imem_we, 1'b0);
        total++;
        if (imem_waddr !== '0 || imem_wdata !== '0) begin
            bad++;
            $display("FAIL mid_wbus got=%0d/%h want=0/0", imem_waddr, imem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(10'd0, 32'h1234_5678, 1'b0);
        send_word(10'd1, 32'h9ABC_DEF0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0, 1'b0);
`endif
        wait_end("reload");
        chk1("reload_done", done, 1'b1);
    endtask

    initial begin
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_gaps();
        test_zero_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_len_limit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
